// File: rtl/row_chunk_feeder_if.sv
// Bundle between the row chunk feeder, its chunk buffer and the row-adder organizer.
// slave = the feeder itself, master = the surrounding lane.
interface row_chunk_feeder_if #(
  parameter int element_width = 32,
  parameter int no_of_units   = 8,
  parameter int addr_width    = 6
);
  localparam int DW = element_width * no_of_units;

  logic                     go;
  logic [addr_width:0]      row_chunks;
  logic                     mem_rd_en;
  logic [addr_width-1:0]    mem_addr;
  logic [DW-1:0]            mem_rd_data;
  logic [DW-1:0]            adder_row_input;
  logic                     outsider4;
  logic                     start;
  logic                     final_adder_finish_dash;
  logic [element_width-1:0] adder_output;
  logic [element_width-1:0] result;
  logic                     result_valid;
  logic                     busy;
  logic                     timeout_err;

  modport master (
    output go,
    output row_chunks,
    output mem_rd_data,
    output final_adder_finish_dash,
    output adder_output,
    input  mem_rd_en,
    input  mem_addr,
    input  adder_row_input,
    input  outsider4,
    input  start,
    input  result,
    input  result_valid,
    input  busy,
    input  timeout_err
  );

  modport slave (
    input  go,
    input  row_chunks,
    input  mem_rd_data,
    input  final_adder_finish_dash,
    input  adder_output,
    output mem_rd_en,
    output mem_addr,
    output adder_row_input,
    output outsider4,
    output start,
    output result,
    output result_valid,
    output busy,
    output timeout_err
  );
endinterface

// File: rtl/row_chunk_feeder.sv
// Streams one row of chunks into the row-adder organizer and returns its sum.
// Optional drain watchdog: define ROW_CHUNK_FEEDER_TIMEOUT_EN.
module row_chunk_feeder #(
  parameter int element_width  = 32,
  parameter int no_of_units    = 8,
  parameter int addr_width     = 6,
  parameter int timeout_cycles = 255
) (
  input logic               clk,
  input logic               rst_n,
  row_chunk_feeder_if.slave bus
);
  localparam int DW = element_width * no_of_units;
  localparam int CW = addr_width + 1;
  localparam logic [CW-1:0] MAX_N =
    {1'b1, {addr_width{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [CW-1:0]            n_q, n_d;
  logic [addr_width-1:0]    addr_q, addr_d;
  logic                     rd_en_q, rd_en_d;
  logic                     pend_q, pend_d;
  logic [DW-1:0]            row_q, row_d;
  logic                     o4_q, o4_d;
  logic                     start_q, start_d;
  logic [element_width-1:0] result_q, result_d;
  logic                     rv_q, rv_d;
  logic                     busy_q, busy_d;

  logic [CW-1:0]            go_n;
  logic                     drained;
  logic                     last_rd;

`ifdef ROW_CHUNK_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(timeout_cycles + 1) + 1;
  logic [TW-1:0]            cnt_q, cnt_d;
  logic                     terr_q, terr_d;
`endif

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    addr_d   = addr_q;
    rd_en_d  = rd_en_q;
    // read data lands one cycle after the strobe
    pend_d   = rd_en_q;
    o4_d     = pend_q;
    row_d    = pend_q ? bus.mem_rd_data : '0;
    start_d  = start_q | pend_q;
    result_d = result_q;
    rv_d     = 1'b0;
    busy_d   = busy_q;
`ifdef ROW_CHUNK_FEEDER_TIMEOUT_EN
    cnt_d    = cnt_q;
    terr_d   = terr_q;
`endif
    go_n     = (bus.row_chunks > MAX_N) ?
               MAX_N : bus.row_chunks;
    drained  = !rd_en_q && !pend_q;
    last_rd  = ({1'b0, addr_q} + CW'(1)) == n_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          start_d = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        if (bus.go) begin
          busy_d = 1'b1;
          n_d    = go_n;
          if (go_n == '0) begin
            state_d  = DONE;
            result_d = '0;
            rv_d     = 1'b1;
          end else begin
            state_d = FETCH;
            rd_en_d = 1'b1;
            addr_d  = '0;
          end
        end
      end
      FETCH: begin
        if (last_rd) begin
          rd_en_d = 1'b0;
          addr_d  = '0;
          state_d = DRAIN;
`ifdef ROW_CHUNK_FEEDER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          addr_d = addr_q + addr_width'(1);
        end
      end
      DRAIN: begin
        if (drained && bus.final_adder_finish_dash) begin
          result_d = bus.adder_output;
          rv_d     = 1'b1;
          state_d  = DONE;
        end
`ifdef ROW_CHUNK_FEEDER_TIMEOUT_EN
        else if (drained) begin
          if (cnt_q == TW'(timeout_cycles)) begin
            terr_d   = 1'b1;
            result_d = '0;
            rv_d     = 1'b1;
            state_d  = DONE;
          end else begin
            cnt_d = cnt_q + TW'(1);
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      n_q      <= '0;
      addr_q   <= '0;
      rd_en_q  <= 1'b0;
      pend_q   <= 1'b0;
      row_q    <= '0;
      o4_q     <= 1'b0;
      start_q  <= 1'b0;
      result_q <= '0;
      rv_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      addr_q   <= addr_d;
      rd_en_q  <= rd_en_d;
      pend_q   <= pend_d;
      row_q    <= row_d;
      o4_q     <= o4_d;
      start_q  <= start_d;
      result_q <= result_d;
      rv_q     <= rv_d;
      busy_q   <= busy_d;
    end
  end

`ifdef ROW_CHUNK_FEEDER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      terr_q <= terr_d;
    end
  end

  assign bus.timeout_err = terr_q;
`else
  localparam int unused_timeout = timeout_cycles;
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.mem_rd_en       = rd_en_q;
  assign bus.mem_addr        = addr_q;
  assign bus.adder_row_input = row_q;
  assign bus.outsider4       = o4_q;
  assign bus.start           = start_q;
  assign bus.result          = result_q;
  assign bus.result_valid    = rv_q;
  assign bus.busy            = busy_q;
endmodule

// File: tb/tb_row_chunk_feeder.sv
// Scoreboard bench for row_chunk_feeder: expected cycle-stamped events are
// queued at issue time and a monitor checks every cycle.
module tb_row_chunk_feeder;
  localparam int EW = 32;
  localparam int NU = 8;
  localparam int AW = 6;
  localparam int DW = EW * NU;
`ifdef ROW_CHUNK_FEEDER_TIMEOUT_EN
  localparam int TO = 10;
`else
  localparam int TO = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    int            cyc;
    logic [DW-1:0] val;
  } exp_t;

  exp_t aq[$];
  exp_t cq[$];
  exp_t rq[$];
  bit   busy_at[int];
  bit   start_at[int];
  int   terr_from = -1;

  logic [DW-1:0] mem [64];

  row_chunk_feeder_if #(
    .element_width(EW),
    .no_of_units  (NU),
    .addr_width   (AW)
  ) bus ();

  row_chunk_feeder #(
    .element_width (EW),
    .no_of_units   (NU),
    .addr_width    (AW),
    .timeout_cycles(10)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] rnd_row();
    logic [DW-1:0] r;
    for (int i = 0; i < NU; i++) r[i*EW +: EW] = $urandom;
    return r;
  endfunction

  // chunk buffer: one-cycle read latency, junk when not reading
  always @(posedge clk)
    bus.mem_rd_data <= bus.mem_rd_en ? mem[bus.mem_addr] : rnd_row();

  task automatic chk(input string nm,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic void clear_model();
    aq.delete();
    cq.delete();
    rq.delete();
    busy_at.delete();
    start_at.delete();
    terr_from = -1;
  endfunction

  task automatic mon();
    exp_t e;
    bit   ex;
    ex = aq.size() > 0 && aq[0].cyc == cyc;
    chk("mem_rd_en", DW'(bus.mem_rd_en), DW'(ex));
    if (ex) begin
      e = aq.pop_front();
      chk("mem_addr", DW'(bus.mem_addr), e.val);
    end
    ex = cq.size() > 0 && cq[0].cyc == cyc;
    chk("outsider4", DW'(bus.outsider4), DW'(ex));
    if (ex) begin
      e = cq.pop_front();
      chk("chunk", bus.adder_row_input, e.val);
    end else begin
      chk("row_zero", bus.adder_row_input, '0);
    end
    ex = rq.size() > 0 && rq[0].cyc == cyc;
    chk("result_valid", DW'(bus.result_valid), DW'(ex));
    if (ex) begin
      e = rq.pop_front();
      chk("result", DW'(bus.result), e.val);
    end
    chk("busy", DW'(bus.busy), DW'(busy_at.exists(cyc)));
    chk("start", DW'(bus.start), DW'(start_at.exists(cyc)));
    chk("timeout_err", DW'(bus.timeout_err),
        DW'(terr_from >= 0 && cyc >= terr_from));
  endtask

  always @(posedge clk) begin
    #2;
    mon();
  end

  task automatic chk_all_zero();
    chk("rst_rd_en", DW'(bus.mem_rd_en), '0);
    chk("rst_addr", DW'(bus.mem_addr), '0);
    chk("rst_row", bus.adder_row_input, '0);
    chk("rst_o4", DW'(bus.outsider4), '0);
    chk("rst_start", DW'(bus.start), '0);
    chk("rst_result", DW'(bus.result), '0);
    chk("rst_rv", DW'(bus.result_valid), '0);
    chk("rst_busy", DW'(bus.busy), '0);
    chk("rst_terr", DW'(bus.timeout_err), '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_model();
    bus.go = 1'b0;
    bus.final_adder_finish_dash = 1'b0;
    #1;
    chk_all_zero();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.go = 1'b0;
    bus.final_adder_finish_dash = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge of the result_valid cycle.
  task automatic run_row(input int rc, input int d,
                         input logic [EW-1:0] res,
                         input bit early, input bit xgo,
                         input bit hang);
    int  n, b, rv, endc, last;
    bit  fin, efin;
    n    = rc > 64 ? 64 : rc;
    b    = cyc + 1;
    last = b + n + 1;
    for (int k = 0; k < n; k++) begin
      aq.push_back('{b + k, DW'(k)});
      cq.push_back('{b + 2 + k, mem[k]});
    end
    if (n == 0) rv = b;
    else if (hang) rv = (TO > 0) ? last + TO + 1 : -1;
    else rv = last + d + 1;
    endc = (rv >= 0) ? rv : last + 1000;
    for (int c = b; c <= endc; c++) busy_at[c] = 1'b1;
    if (n > 0)
      for (int c = b + 2; c <= endc; c++) start_at[c] = 1'b1;
    if (rv >= 0)
      rq.push_back('{rv, (n == 0 || hang) ? '0 : DW'(res)});
    if (hang && rv >= 0) terr_from = rv;
    bus.row_chunks = (AW+1)'(rc);
    bus.go = 1'b1;
    while (cyc < endc) begin
      @(negedge clk);
      bus.go = xgo && cyc == b + 1;
      efin = early && n > 0 && cyc == b + 1;
      fin  = !hang && n > 0 && cyc == rv - 1;
      bus.final_adder_finish_dash = fin || efin;
      bus.adder_output = fin ? res : $urandom;
    end
    bus.go = 1'b0;
    bus.final_adder_finish_dash = 1'b0;
  endtask

  initial begin
    int b;
    rst_n = 1'b0;
    bus.go = 1'b0;
    bus.row_chunks = '0;
    bus.final_adder_finish_dash = 1'b0;
    bus.adder_output = '0;
    for (int k = 0; k < 64; k++) mem[k] = rnd_row();
    repeat (3) @(negedge clk);
    chk_all_zero();
    rst_n = 1'b1;
    @(negedge clk);

    // N=3, chunk k filled with k+1, finish 4 cycles after last chunk
    for (int k = 0; k < 3; k++) mem[k] = {NU{EW'(k + 1)}};
    run_row(3, 4, 32'h30, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("busy_after", DW'(bus.busy), '0);
    chk("result_hold", DW'(bus.result), DW'(32'h30));
    idle(2);

    // empty row
    run_row(0, 0, 32'hdead, 1'b0, 1'b0, 1'b0);
    idle(2);

    // oversized row clamps to 64 chunks
    for (int k = 0; k < 64; k++) mem[k] = rnd_row();
    run_row(100, 2, $urandom, 1'b0, 1'b0, 1'b0);
    idle(2);

    // go and finish pulsed mid-fetch are ignored
    for (int k = 0; k < 64; k++) mem[k] = rnd_row();
    run_row(5, 1, $urandom, 1'b1, 1'b1, 1'b0);
    // back-to-back rows, including finish with the last chunk
    run_row(4, 0, $urandom, 1'b0, 1'b0, 1'b0);
    run_row(0, 0, $urandom, 1'b0, 1'b0, 1'b0);
    run_row(1, 3, $urandom, 1'b0, 1'b0, 1'b0);
    idle(2);

    // reset in cycle 5 of an N=8 row
    for (int k = 0; k < 64; k++) mem[k] = rnd_row();
    b = cyc + 1;
    for (int k = 0; k < 8; k++) begin
      aq.push_back('{b + k, DW'(k)});
      cq.push_back('{b + 2 + k, mem[k]});
    end
    for (int c = b; c <= b + 20; c++) busy_at[c] = 1'b1;
    for (int c = b + 2; c <= b + 20; c++) start_at[c] = 1'b1;
    bus.row_chunks = (AW+1)'(8);
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    repeat (4) @(negedge clk);
    do_reset();
    run_row(8, 2, $urandom, 1'b0, 1'b0, 1'b0);
    idle(2);

    // randomized rows
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 64; k++) mem[k] = rnd_row();
      run_row($urandom_range(0, 72), $urandom_range(0, 5), $urandom,
              bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
              1'b0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(2);

    // organizer never finishes
    run_row(2, 0, 32'h0, 1'b0, 1'b0, 1'b1);
    if (TO == 0) begin
      chk("hang_busy", DW'(bus.busy), DW'(1));
    end else begin
      idle(2);
      run_row(3, 1, $urandom, 1'b0, 1'b0, 1'b0);
      idle(1);
    end
    do_reset();
    idle(2);

    chk("addr_q_empty", DW'(aq.size()), '0);
    chk("chunk_q_empty", DW'(cq.size()), '0);
    chk("result_q_empty", DW'(rq.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
